// File: rtl/level_map_arbiter.sv
// level_map_arbiter
//   Shares the single-port synchronous level-map ROM between the pixel
//   pipeline tile fetch and game-logic collision queries.
//
//   The display fetch has absolute priority and a hard deadline. A tile
//   fetch is issued LOOKAHEAD pixels before each tile boundary. Its result
//   is parked in nextType and then moved into blockType on the boundary.
//   Collision queries use a level req/ack handshake. They are served in the
//   ROM slots that the display fetch leaves free.
//
//   Build option: define QUERY_OOB_SOLID_EN to make out-of-range queries
//   return qType=1 (solid). Without it they return qType=0 (empty).
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pix_en     pixel-advance strobe (hCount/vCount move on edges with pix_en=1)
//   hCount     current pixel x
//   vCount     current pixel y
//   romEn      ROM read enable (registered)
//   romAddr    ROM address row*MAP_COLS+col (registered)
//   romData    ROM data, valid the cycle after the ROM samples romEn/romAddr
//   blockType  tile type of the current pixel
//   qReq       query request, level, held until qAck
//   qCol       query tile column
//   qRow       query tile row
//   qAck       one-cycle pulse, qType valid
//   qType      query result, held until the next qAck
module level_map_arbiter #(
   parameter int H_START    = 144,
   parameter int V_START    = 35,
   parameter int MAP_COLS   = 20,
   parameter int MAP_ROWS   = 15,
   parameter int TILE_SHIFT = 5,
   parameter int LOOKAHEAD  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   output logic       romEn,
   output logic [8:0] romAddr,
   input  logic [2:0] romData,
   output logic [2:0] blockType,
   input  logic       qReq,
   input  logic [4:0] qCol,
   input  logic [3:0] qRow,
   output logic       qAck,
   output logic [2:0] qType
);

   localparam int V_END = V_START + (MAP_ROWS << TILE_SHIFT);

`ifdef QUERY_OOB_SOLID_EN
   localparam logic [2:0] OOB_TYPE = 3'd1;
`else
   localparam logic [2:0] OOB_TYPE = 3'd0;
`endif

   // row*20 + col built from shifts: (row<<4) + (row<<2) + col.
   function automatic logic [8:0] tileAddr(input logic [3:0] row, input logic [4:0] col);
      logic [8:0] r9;
      r9 = {5'd0, row};
      return (r9 << 4) + (r9 << 2) + {4'd0, col};
   endfunction

   logic [10:0] fetchPos;
   logic [10:0] fetchCol;
   logic [10:0] nextPos;
   logic [10:0] nextCol;
   logic [9:0]  vRel;
   logic [3:0]  dispRow;
   logic [8:0]  dispAddr;
   logic [8:0]  qAddr;
   logic        vActive;
   logic        dispIssue;
   logic        qOob;
   logic        qFree;
   logic        qIssue;
   logic        oobHit;
   logic        loadTile;
   logic        clearTile;

   logic        tagDisp_p1;
   logic        tagQry_p1;
   logic        tagDisp_p2;
   logic        tagQry_p2;
   logic [2:0]  nextType;
   logic        qBusy;

   always_comb begin
      // Positions left of H_START wrap to large values. Their tile index is
      // then out of range, so no separate "before visible area" test is needed.
      fetchPos  = {1'b0, hCount} + 11'(LOOKAHEAD) - 11'(H_START);
      fetchCol  = fetchPos >> TILE_SHIFT;
      nextPos   = {1'b0, hCount} + 11'd1 - 11'(H_START);
      nextCol   = nextPos >> TILE_SHIFT;
      vActive   = (vCount >= 10'(V_START)) && (vCount < 10'(V_END));
      vRel      = vCount - 10'(V_START);
      dispRow   = 4'(vRel >> TILE_SHIFT);
      dispAddr  = tileAddr(dispRow, fetchCol[4:0]);
      dispIssue = pix_en && vActive &&
                  (fetchPos[TILE_SHIFT-1:0] == '0) && (fetchCol < 11'(MAP_COLS));

      qOob   = (qCol >= 5'(MAP_COLS)) || (qRow >= 4'(MAP_ROWS));
      qAddr  = tileAddr(qRow, qCol);
      // While qAck is high the requester has not yet had an edge to drop
      // qReq, so a still-high qReq in that cycle is the old request.
      qFree  = qReq && !qBusy && !qAck;
      qIssue = qFree && !qOob && !dispIssue;
      oobHit = qFree && qOob;

      loadTile  = pix_en && vActive &&
                  (nextPos[TILE_SHIFT-1:0] == '0) && (nextCol < 11'(MAP_COLS));
      clearTile = pix_en && (!vActive ||
                  ((nextPos[TILE_SHIFT-1:0] == '0) && (nextCol == 11'(MAP_COLS))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         romEn      <= 1'b0;
         romAddr    <= '0;
         tagDisp_p1 <= 1'b0;
         tagQry_p1  <= 1'b0;
         tagDisp_p2 <= 1'b0;
         tagQry_p2  <= 1'b0;
         nextType   <= '0;
         blockType  <= '0;
         qAck       <= 1'b0;
         qType      <= '0;
         qBusy      <= 1'b0;
      end else begin
         // ---- stage p1: issue slot, display wins ----
         romEn <= dispIssue || qIssue;
         if (dispIssue) begin
            romAddr <= dispAddr;
         end else if (qIssue) begin
            romAddr <= qAddr;
         end
         tagDisp_p1 <= dispIssue;
         tagQry_p1  <= qIssue;

         // ---- stage p2: ROM samples address ----
         tagDisp_p2 <= tagDisp_p1;
         tagQry_p2  <= tagQry_p1;

         // ---- capture: route romData by tag ----
         if (tagDisp_p2) begin
            nextType <= romData;
         end

         qAck <= 1'b0;
         if (tagQry_p2) begin
            qType <= romData;
            qAck  <= 1'b1;
            qBusy <= 1'b0;
         end else if (oobHit) begin
            qType <= OOB_TYPE;
            qAck  <= 1'b1;
         end
         if (qIssue) begin
            qBusy <= 1'b1;
         end

         if (loadTile) begin
            blockType <= nextType;
         end else if (clearTile) begin
            blockType <= '0;
         end
      end
   end

endmodule

// File: tb/tb_level_map_arbiter.sv
`timescale 1ns/1ps
module tb_level_map_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_en;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       romEn;
   logic [8:0] romAddr;
   logic [2:0] romData = 3'd0;
   logic [2:0] blockType;
   logic       qReq;
   logic [4:0] qCol;
   logic [3:0] qRow;
   logic       qAck;
   logic [2:0] qType;

   int total = 0;
   int bad   = 0;

   logic [2:0] rom [0:299];
   logic [2:0] expQ[$];
   int         addrQ[$];

`ifdef QUERY_OOB_SOLID_EN
   localparam logic [2:0] OOB_EXP = 3'd1;
`else
   localparam logic [2:0] OOB_EXP = 3'd0;
`endif

   level_map_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_en    (pix_en),
      .hCount    (hCount),
      .vCount    (vCount),
      .romEn     (romEn),
      .romAddr   (romAddr),
      .romData   (romData),
      .blockType (blockType),
      .qReq      (qReq),
      .qCol      (qCol),
      .qRow      (qRow),
      .qAck      (qAck),
      .qType     (qType)
   );

   always #5 clk = ~clk;

   // Synchronous single-port ROM model.
   always @(posedge clk) begin
      if (romEn && (romAddr < 9'd300)) romData <= rom[romAddr];
   end

   task automatic test_reset();
      rst_n = 1'b0; pix_en = 1'b1; hCount = 10'd0; vCount = 10'd10;
      qReq = 1'b0; qCol = 5'd0; qRow = 4'd0;
      repeat (3) @(negedge clk);
      total++; if (romEn !== 1'b0) begin bad++; $display("FAIL reset_romEn: got %0d want 0", romEn); end
      total++; if (romAddr !== 9'd0) begin bad++; $display("FAIL reset_romAddr: got %0d want 0", romAddr); end
      total++; if (blockType !== 3'd0) begin bad++; $display("FAIL reset_blockType: got %0d want 0", blockType); end
      total++; if (qAck !== 1'b0) begin bad++; $display("FAIL reset_qAck: got %0d want 0", qAck); end
      total++; if (qType !== 3'd0) begin bad++; $display("FAIL reset_qType: got %0d want 0", qType); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_display();
      int p;
      int x;
      int a;
      logic [2:0] expBt;
      vCount = 10'd105; qReq = 1'b0;
      for (int h = 130; h <= 800; h++) begin
         hCount = 10'(h);
         p = h + 4 - 144;
         if (p >= 0 && (p % 32) == 0 && (p / 32) < 20) addrQ.push_back(40 + p / 32);
         @(negedge clk);
         if (romEn === 1'b1) begin
            total++;
            if (addrQ.size() == 0) begin
               bad++; $display("FAIL disp_spurious_issue: romAddr=%0d at hCount=%0d want no issue", romAddr, h);
            end else begin
               a = addrQ.pop_front();
               if (romAddr !== 9'(a)) begin bad++; $display("FAIL disp_addr: got %0d want %0d at hCount=%0d", romAddr, a, h); end
            end
         end else if (addrQ.size() != 0) begin
            total++; bad++;
            a = addrQ.pop_front();
            $display("FAIL disp_missed_issue: romEn=%0d want 1 (addr %0d) at hCount=%0d", romEn, a, h);
         end
         x = h + 1;
         expBt = (x >= 144 && x < 784) ? rom[40 + (x - 144) / 32] : 3'd0;
         total++;
         if (blockType !== expBt) begin bad++; $display("FAIL disp_blockType: got %0d want %0d at pixel %0d", blockType, expBt, x); end
      end
   endtask

   task automatic test_query();
      int  lat;
      bit  got;
      int  extra;
      logic [2:0] e;
      vCount = 10'd10; hCount = 10'd0;
      @(negedge clk);
      qCol = 5'd7; qRow = 4'd3; qReq = 1'b1; expQ.push_back(rom[67]);
      lat = 0; got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk); lat++;
         if (c == 0) begin
            total++;
            if (romEn !== 1'b1 || romAddr !== 9'd67) begin bad++; $display("FAIL query_issue: romEn=%0d romAddr=%0d want 1/67", romEn, romAddr); end
         end
         if (qAck === 1'b1) got = 1;
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL query_ack_timeout: no qAck within %0d cycles", lat);
      end else begin
         if (lat != 3) begin bad++; $display("FAIL query_ack_latency: got %0d want 3", lat); end
         e = expQ.pop_front();
         total++;
         if (qType !== e) begin bad++; $display("FAIL query_qType: got %0d want %0d", qType, e); end
      end
      qReq = 1'b0;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (qAck === 1'b1) extra++;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL query_single_ack: extra acks %0d want 0", extra); end
      total++; if (qType !== rom[67]) begin bad++; $display("FAIL query_qType_held: got %0d want %0d", qType, rom[67]); end
   endtask

   task automatic test_conflict();
      int extra;
      logic [2:0] e;
      vCount = 10'd105; hCount = 10'd139; qReq = 1'b0;
      @(negedge clk);
      hCount = 10'd140; qCol = 5'd5; qRow = 4'd1; qReq = 1'b1; expQ.push_back(rom[25]);
      @(negedge clk);
      total++; if (romEn !== 1'b1 || romAddr !== 9'd40) begin bad++; $display("FAIL conflict_disp_first: romEn=%0d romAddr=%0d want 1/40", romEn, romAddr); end
      hCount = 10'd141;
      @(negedge clk);
      total++; if (romEn !== 1'b1 || romAddr !== 9'd25) begin bad++; $display("FAIL conflict_query_second: romEn=%0d romAddr=%0d want 1/25", romEn, romAddr); end
      hCount = 10'd142;
      @(negedge clk);
      total++; if (qAck !== 1'b0) begin bad++; $display("FAIL conflict_ack_early: qAck=%0d want 0", qAck); end
      hCount = 10'd143;
      @(negedge clk);
      total++; if (qAck !== 1'b1) begin bad++; $display("FAIL conflict_ack_delayed: qAck=%0d want 1", qAck); end
      e = expQ.pop_front();
      total++; if (qType !== e) begin bad++; $display("FAIL conflict_qType: got %0d want %0d", qType, e); end
      total++; if (blockType !== rom[40]) begin bad++; $display("FAIL conflict_blockType0: got %0d want %0d", blockType, rom[40]); end
      qReq = 1'b0;
      extra = 0;
      for (int h = 144; h <= 175; h++) begin
         hCount = 10'(h);
         @(negedge clk);
         if (qAck === 1'b1) extra++;
         if (h == 172) begin
            total++;
            if (romEn !== 1'b1 || romAddr !== 9'd41) begin bad++; $display("FAIL conflict_disp_next: romEn=%0d romAddr=%0d want 1/41", romEn, romAddr); end
         end
      end
      total++; if (extra != 0) begin bad++; $display("FAIL conflict_extra_ack: got %0d want 0", extra); end
      total++; if (blockType !== rom[41]) begin bad++; $display("FAIL conflict_blockType1: got %0d want %0d", blockType, rom[41]); end
   endtask

   task automatic test_oob();
      logic [2:0] e;
      vCount = 10'd10; hCount = 10'd0;
      @(negedge clk);
      qCol = 5'd20; qRow = 4'd0; qReq = 1'b1; expQ.push_back(OOB_EXP);
      @(negedge clk);
      total++; if (romEn !== 1'b0) begin bad++; $display("FAIL oob_col_romEn: got %0d want 0", romEn); end
      total++; if (qAck !== 1'b1) begin bad++; $display("FAIL oob_col_ack: got %0d want 1", qAck); end
      e = expQ.pop_front();
      total++; if (qType !== e) begin bad++; $display("FAIL oob_col_qType: got %0d want %0d", qType, e); end
      qReq = 1'b0;
      @(negedge clk);
      total++; if (qAck !== 1'b0) begin bad++; $display("FAIL oob_ack_pulse: got %0d want 0", qAck); end
      qCol = 5'd0; qRow = 4'd15; qReq = 1'b1; expQ.push_back(OOB_EXP);
      @(negedge clk);
      total++; if (romEn !== 1'b0 || qAck !== 1'b1) begin bad++; $display("FAIL oob_row: romEn=%0d qAck=%0d want 0/1", romEn, qAck); end
      e = expQ.pop_front();
      total++; if (qType !== e) begin bad++; $display("FAIL oob_row_qType: got %0d want %0d", qType, e); end
      qReq = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int  lat;
      bit  got;
      int  extra;
      logic [2:0] e;
      vCount = 10'd10; hCount = 10'd0;
      qCol = 5'd2; qRow = 4'd4; qReq = 1'b1; expQ.push_back(rom[82]);
      @(negedge clk);
      total++; if (romEn !== 1'b1 || romAddr !== 9'd82) begin bad++; $display("FAIL rstmid_issue: romEn=%0d romAddr=%0d want 1/82", romEn, romAddr); end
      rst_n = 1'b0;
      #1;
      total++;
      if (romEn !== 1'b0 || romAddr !== 9'd0 || blockType !== 3'd0 || qAck !== 1'b0 || qType !== 3'd0) begin
         bad++;
         $display("FAIL rstmid_clear: romEn=%0d romAddr=%0d blockType=%0d qAck=%0d qType=%0d want all 0", romEn, romAddr, blockType, qAck, qType);
      end
      @(negedge clk);
      total++; if (qAck !== 1'b0) begin bad++; $display("FAIL rstmid_no_ack: got %0d want 0", qAck); end
      rst_n = 1'b1;
      lat = 0; got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk); lat++;
         if (c == 0) begin
            total++;
            if (romEn !== 1'b1 || romAddr !== 9'd82) begin bad++; $display("FAIL rstmid_reissue: romEn=%0d romAddr=%0d want 1/82", romEn, romAddr); end
         end
         if (qAck === 1'b1) got = 1;
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL rstmid_ack_timeout: no qAck within %0d cycles", lat);
      end else begin
         if (lat != 3) begin bad++; $display("FAIL rstmid_ack_latency: got %0d want 3", lat); end
         e = expQ.pop_front();
         total++;
         if (qType !== e) begin bad++; $display("FAIL rstmid_qType: got %0d want %0d", qType, e); end
      end
      qReq = 1'b0;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (qAck === 1'b1) extra++;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL rstmid_extra_ack: got %0d want 0", extra); end
   endtask

   task automatic test_back_to_back();
      int cols [5] = '{0, 19, 7, 1, 10};
      int rows [5] = '{0, 14, 3, 2, 9};
      int acks;
      int cyc;
      int lastAck;
      int extra;
      logic [2:0] e;
      vCount = 10'd10; hCount = 10'd0;
      @(negedge clk);
      qCol = 5'(cols[0]); qRow = 4'(rows[0]); qReq = 1'b1;
      expQ.push_back(rom[rows[0] * 20 + cols[0]]);
      acks = 0; cyc = 0; lastAck = 0;
      while (acks < 5 && cyc < 60) begin
         @(negedge clk); cyc++;
         if (qAck === 1'b1) begin
            total++;
            if (expQ.size() == 0) begin
               bad++; $display("FAIL b2b_unexpected_ack: qType=%0d at cycle %0d", qType, cyc);
            end else begin
               e = expQ.pop_front();
               if (qType !== e) begin bad++; $display("FAIL b2b_qType: ack %0d got %0d want %0d", acks, qType, e); end
            end
            if (acks > 0) begin
               total++;
               if (cyc - lastAck < 3) begin bad++; $display("FAIL b2b_spacing: got %0d cycles want >= 3", cyc - lastAck); end
            end
            lastAck = cyc;
            acks++;
            if (acks < 5) begin
               qCol = 5'(cols[acks]); qRow = 4'(rows[acks]);
               expQ.push_back(rom[rows[acks] * 20 + cols[acks]]);
            end else begin
               qReq = 1'b0;
            end
         end
      end
      total++; if (acks != 5) begin bad++; $display("FAIL b2b_ack_count: got %0d want 5", acks); end
      qReq = 1'b0;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (qAck === 1'b1) extra++;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL b2b_extra_ack: got %0d want 0", extra); end
   endtask

   initial begin
      for (int i = 0; i < 300; i++) rom[i] = 3'((i * 5 + 3) % 8);
      rom[40] = 3'd1;
      rom[41] = 3'd3;
      rom[67] = 3'd2;
      rom[25] = 3'd6;
      test_reset();
      test_display();
      test_query();
      test_conflict();
      test_oob();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/level_map_arbiter.md
Name: level_map_arbiter

Overview:
- Shares the single-port synchronous level-map ROM between two requesters: the pixel-pipeline tile fetch and game-logic collision queries.
- The pixel fetch produces the registered blockType that feeds the painting logic. It has a hard deadline and absolute priority.
- Collision queries use a req/ack handshake and are served in the ROM slots the pixel fetch does not use.

Parameters:
- H_START, 144, hCount of first visible column
- V_START, 35, vCount of first visible row
- MAP_COLS, 20, tiles per row
- MAP_ROWS, 15, tile rows
- TILE_SHIFT, 5, log2 of tile size (32 px)
- LOOKAHEAD, 4, pixels before a tile boundary at which its fetch is issued; must be >= 4

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-advance strobe; hCount/vCount change on clk edges where pix_en=1
- hCount  in  10  current pixel x
- vCount  in  10  current pixel y
- romEn  out  1  ROM read enable (registered)
- romAddr  out  9  ROM address, row*MAP_COLS+col (registered)
- romData  in  3  ROM data, valid the cycle after the ROM samples romEn/romAddr
- blockType  out  3  tile type of the current pixel
- qReq  in  1  query request, level, held until qAck
- qCol  in  5  query tile column
- qRow  in  4  query tile row
- qAck  out  1  one-cycle pulse: qType valid
- qType  out  3  query result, held until the next qAck

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low (rst_n). Reset clears romEn, romAddr, blockType, next_type, qAck, qType, the tag pipeline and the outstanding flag, all to 0.
- Reset mid-operation drops any outstanding query with no qAck. A qReq still held after release is served as a new request.
- Read pipeline:
  - At most one issue per clk.
  - Issue edge N registers romEn/romAddr and pushes a tag {DISP, QRY} into a 2-deep tag pipeline.
  - The ROM samples at N+1. The arbiter captures romData at N+2 and routes it by tag.
  - Fixed issue-to-capture latency is 2 edges.
- Display fetch point:
  - Let p = hCount + LOOKAHEAD - H_START.
  - Issue when pix_en=1, (p & 31)==0, p>>5 < MAP_COLS, and V_START <= vCount < V_START+32*MAP_ROWS.
  - Address = ((vCount-V_START)>>5)*MAP_COLS + (p>>5).
  - Multiply by shift-add, (r<<4)+(r<<2)+c. Maximum address is 299.
  - The captured result goes to next_type.
- blockType update, on an edge with pix_en=1:
  - If hCount+1-H_START is a multiple of 32 with tile index < MAP_COLS and the vertical range is active, load blockType <= next_type.
  - If the index equals MAP_COLS, or vCount is outside the active range, load blockType <= 0.
  - blockType is otherwise held.
- Arbitration:
  - A display issue always wins the slot.
  - A query issues when qReq=1, no query is outstanding, and there is no display issue this edge.
  - A blocked query issues on the next free edge.
- Query handshake:
  - At the capture edge (issue+2) set qType <= romData and pulse qAck for exactly one cycle. Clear the outstanding flag at the same edge.
  - Earliest qAck is the cycle after edge N+2, where N is the first edge sampling qReq=1. The requester may drop qReq at that edge.
  - If qReq is still 1 in the cycle after qAck, it is a new request.
- Out-of-range query (qCol>=MAP_COLS or qRow>=MAP_ROWS):
  - No ROM issue.
  - qAck is asserted the cycle after the edge sampling the request.
  - qType follows the Optional Feature.
- Simultaneous display issue and query capture is legal: the tag routes the data. A query never corrupts next_type or blockType.

Optional Feature:
- Macro: QUERY_OOB_SOLID_EN.
- When defined, out-of-range queries return qType=1 (foreground block), making the map boundary solid for collision.
- When undefined, they return qType=0 (empty).

Test Plan:
- pix_en=1 every clk; ROM model with tile (row 2, col 0)=1 and (row 2, col 1)=3; vCount=V_START+70 -> romAddr=40 at hCount=140 and 41 at hCount=172; blockType=1 for hCount 144..175, 3 for 176..207, 0 at hCount>=784.
- Idle display (vCount=10), qReq=1 with qCol=7, qRow=3, ROM[67]=2 -> romAddr=67 issued at first edge; qAck pulses exactly once, two edges later; qType=2 held.
- qReq raised on the edge where display issues at hCount=140 -> display address on romAddr first, query address one edge later; qAck delayed one cycle; blockType is unaffected.
- qCol=20, qRow=0 -> no romEn; qAck the next cycle; qType=1 with QUERY_OOB_SOLID_EN, 0 without.
- rst_n pulsed low the cycle after a query issue -> all outputs 0 immediately; no qAck; held qReq is re-issued and acked after release.
- qReq held high continuously -> back-to-back acks at most every 3 cycles; each ack matches the ROM contents.
